// File: rtl/div_seq_32_pkg.sv
// Shared definitions for the sequential signed divider.
package div_seq_32_pkg;

    localparam int unsigned DIV_WIDTH  = 32;
    localparam int unsigned DIV_CNT_W  = 6;
    localparam logic [3:0]  ALU_OP_DIV = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // Magnitude of a two's complement value; 0x80000000 maps to unsigned 2**31.
    function automatic logic [DIV_WIDTH-1:0] mag(input logic [DIV_WIDTH-1:0] v);
        return v[DIV_WIDTH-1] ? -v : v;
    endfunction

endpackage

// File: rtl/div_step_33.sv
// One non-restoring iteration on the 33-bit partial remainder.
module div_step_33 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0] p_i,
    input  logic [WIDTH:0] d_i,
    input  logic           bit_i,
    output logic [WIDTH:0] p_o,
    output logic           q_o
);

    logic [WIDTH:0] p_sh;

    // Shift in the next dividend bit, then subtract or add the divisor by remainder sign.
    always_comb begin
        p_sh = {p_i[WIDTH-1:0], bit_i};
        p_o  = p_i[WIDTH] ? (p_sh + d_i) : (p_sh - d_i);
        q_o  = ~p_o[WIDTH];
    end

endmodule

// File: rtl/div_seq_32.sv
// Multi-cycle signed divider: quotient on rZLO, remainder on rZHI.
module div_seq_32
    import div_seq_32_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned CNT_W = DIV_CNT_W
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic [WIDTH-1:0] rA,
    input  logic [WIDTH-1:0] rB,
    output logic [WIDTH-1:0] rZLO,
    output logic [WIDTH-1:0] rZHI,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   p_q, p_d;
    logic [WIDTH:0]   d_q, d_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic [WIDTH-1:0] zlo_q, zlo_d;
    logic [WIDTH-1:0] zhi_q, zhi_d;
    logic             dz_q, dz_d;

    logic [WIDTH:0]   p_step;
    logic             q_bit;
    logic [WIDTH:0]   p_fix;
    logic [WIDTH-1:0] rem_mag;

    div_step_33 #(.WIDTH(WIDTH)) u_step (
        .p_i   (p_q),
        .d_i   (d_q),
        .bit_i (q_q[WIDTH-1]),
        .p_o   (p_step),
        .q_o   (q_bit)
    );

    // Next-state and datapath update for the divide sequence.
    // The quotient bit taken from the post-step sign equals the restoring
    // quotient bit, so only the remainder needs the final correction.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        d_d     = d_q;
        q_d     = q_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        zlo_d   = zlo_q;
        zhi_d   = zhi_q;
        dz_d    = dz_q;
        p_fix   = p_q[WIDTH] ? (p_q + d_q) : p_q;
        rem_mag = p_fix[WIDTH-1:0];
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d  = rA[WIDTH-1];
                    sb_d  = rB[WIDTH-1];
                    q_d   = mag(rA);
                    d_d   = {1'b0, mag(rB)};
                    p_d   = '0;
                    cnt_d = '0;
                    if (rB == '0) begin
                        zlo_d   = '1;
                        zhi_d   = rA;
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        dz_d    = 1'b0;
                        state_d = ITER;
                    end
                end
            end
            ITER: begin
                p_d   = p_step;
                q_d   = {q_q[WIDTH-2:0], q_bit};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                p_d     = p_fix;
                zlo_d   = (sa_q ^ sb_q) ? -q_q : q_q;
                zhi_d   = sa_q ? -rem_mag : rem_mag;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            d_q     <= '0;
            q_q     <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            zlo_q   <= '0;
            zhi_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            d_q     <= d_d;
            q_q     <= q_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            zlo_q   <= zlo_d;
            zhi_q   <= zhi_d;
            dz_q    <= dz_d;
        end
    end

    assign rZLO     = zlo_q;
    assign rZHI     = zhi_q;
    assign div_zero = dz_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_div_seq_32.sv
// Bench for div_seq_32: cycle-level reference model plus hand-computed cases.
module tb_div_seq_32;

    logic        clock   = 1'b0;
    logic        clear_n = 1'b1;
    logic        start   = 1'b0;
    logic [31:0] rA      = '0;
    logic [31:0] rB      = '0;
    logic [31:0] rZLO, rZHI;
    logic        busy, done, div_zero;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    div_seq_32 #(.WIDTH(32), .CNT_W(6)) dut (
        .clock    (clock),
        .clear_n  (clear_n),
        .start    (start),
        .rA       (rA),
        .rB       (rB),
        .rZLO     (rZLO),
        .rZHI     (rZHI),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: an accepted op keeps the unit busy for a fixed number
    // of cycles; results appear together with the single done cycle.
    int          left = 0;
    logic [31:0] m_zlo = '0, m_zhi = '0, p_zlo = '0, p_zhi = '0;
    logic        m_dz = 1'b0;
    longint      ma, mb, mq, mr;

    always @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            left  = 0;
            m_zlo = '0;
            m_zhi = '0;
            m_dz  = 1'b0;
        end else if (left > 0) begin
            left--;
            if (left == 1) begin
                m_zlo = p_zlo;
                m_zhi = p_zhi;
            end
        end else if (start === 1'b1) begin
            if (rB == 32'd0) begin
                m_zlo = 32'hFFFF_FFFF;
                m_zhi = rA;
                m_dz  = 1'b1;
                left  = 1;
            end else begin
                ma    = longint'($signed(rA));
                mb    = longint'($signed(rB));
                mq    = ma / mb;
                mr    = ma % mb;
                p_zlo = mq[31:0];
                p_zhi = mr[31:0];
                m_dz  = 1'b0;
                left  = 34;
            end
        end
    end

    // Compare every output against the model on every falling edge.
    always @(negedge clock) begin
        chk("busy", {31'd0, busy}, {31'd0, left > 0});
        chk("done", {31'd0, done}, {31'd0, left == 1});
        chk("rZLO", rZLO, m_zlo);
        chk("rZHI", rZHI, m_zhi);
        chk("div_zero", {31'd0, div_zero}, {31'd0, m_dz});
    end

    // mode 0: plain, 1: reset at count 10, 2: restart pulse at count 5, 3: random start noise
    task automatic op(input logic [31:0] a, input logic [31:0] b, input int mode,
                      input bit lit, input logic [31:0] eq, input logic [31:0] er, input int elat);
        int n;
        bit got;
        @(posedge clock); #2;
        rA = a; rB = b; start = 1'b1;
        @(posedge clock); #2;
        start = 1'b0; rA = $urandom; rB = $urandom;
        n = 0;
        got = 1'b0;
        while (n < 40 && !got) begin
            @(negedge clock);
            n++;
            if (mode == 1 && n == 11) begin
                #1 clear_n = 1'b0;
                #1;
                chk("rst_busy", {31'd0, busy}, 32'd0);
                chk("rst_done", {31'd0, done}, 32'd0);
                chk("rst_rZLO", rZLO, 32'd0);
                chk("rst_rZHI", rZHI, 32'd0);
                chk("rst_dz", {31'd0, div_zero}, 32'd0);
                @(posedge clock); #2;
                clear_n = 1'b1;
                return;
            end
            if (done === 1'b1) begin
                got = 1'b1;
                start = 1'b0;
            end else if (mode == 2) begin
                start = (n == 6);
                if (n == 6) begin
                    rA = 32'd999;
                    rB = 32'd5;
                end
            end else if (mode == 3) begin
                start = ($urandom_range(0, 3) == 0);
                rA = $urandom;
                rB = $urandom;
            end
        end
        chk("done_seen", {31'd0, got}, 32'd1);
        if (got && lit) begin
            chk("lat", n - 1, elat);
            chk("lit_q", rZLO, eq);
            chk("lit_r", rZHI, er);
            chk("lit_dz", {31'd0, div_zero}, {31'd0, b == 32'd0});
        end
    endtask

    initial begin
        logic [31:0] a, b;
        #1 clear_n = 1'b0;
        #1;
        chk("init_busy", {31'd0, busy}, 32'd0);
        chk("init_done", {31'd0, done}, 32'd0);
        chk("init_rZLO", rZLO, 32'd0);
        chk("init_rZHI", rZHI, 32'd0);
        chk("init_dz", {31'd0, div_zero}, 32'd0);
        #20;
        @(posedge clock); #2;
        clear_n = 1'b1;

        op(32'd7, 32'd2, 0, 1, 32'd3, 32'd1, 33);
        op(32'hFFFF_FFF9, 32'd2, 0, 1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        op(32'd7, 32'hFFFF_FFFE, 0, 1, 32'hFFFF_FFFD, 32'd1, 33);
        op(32'd7, 32'd0, 0, 1, 32'hFFFF_FFFF, 32'd7, 0);
        op(32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 32'h8000_0000, 32'd0, 33);
        op(32'h8000_0000, 32'd3, 0, 1, 32'hD555_5556, 32'hFFFF_FFFE, 33);
        op(32'd12345, 32'd67, 1, 0, 32'd0, 32'd0, 0);
        op(32'd100, 32'd7, 0, 1, 32'd14, 32'd2, 33);
        op(32'd1000000, 32'd13, 2, 1, 32'd76923, 32'd1, 33);
        op(32'h7FFF_FFFF, 32'h8000_0000, 0, 1, 32'd0, 32'h7FFF_FFFF, 33);

        for (int i = 0; i < 60; i++) begin
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = $urandom_range(1, 20);
                3: b = -$urandom_range(1, 20);
                4: begin b = $urandom; a = 32'h8000_0000; end
                default: b = $urandom;
            endcase
            op(a, b, 3, 0, 32'd0, 32'd0, 0);
        end

        repeat (3) @(posedge clock);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
